// File: rtl/spawn_scheduler.sv
// Frame-paced obstacle/coin spawn scheduler: issues one-hot obstacle requests with
// ack/timeout handling and a cooldown, plus independent per-lane coin pulses.
module spawn_scheduler #(
    parameter int NOBST       = 4,
    parameter int NCOIN       = 3,
    parameter int COOLDOWN    = 8,
    parameter int ACK_TIMEOUT = 4,
    parameter int THRESH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             play,
    input  logic [19:0]      rnd,
    input  logic [NOBST-1:0] obst_active,
    input  logic [NCOIN-1:0] coin_active,
    output logic [NOBST-1:0] obst_spawn,
    output logic [NCOIN-1:0] coin_spawn,
    output logic [1:0]       state,
    output logic [15:0]      spawn_count,
    output logic [7:0]       miss_count
);

    localparam int         IW       = $clog2(NOBST);
    localparam logic [3:0] THRESH_L = 4'(THRESH);
    localparam logic [3:0] ACK_TO_L = 4'(ACK_TIMEOUT);
    localparam logic [7:0] COOL_L   = 8'(COOLDOWN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READY  = 2'd1,
        S_FLIGHT = 2'd2,
        S_COOL   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [NOBST-1:0] obst_spawn_q, obst_spawn_d;
    logic [NCOIN-1:0] coin_spawn_q, coin_spawn_d;
    logic [15:0]      spawn_count_q, spawn_count_d;
    logic [7:0]       miss_count_q, miss_count_d;
    logic [IW-1:0]    last_idx_q, last_idx_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       ack_cnt_q, ack_cnt_d;
    logic [7:0]       cool_cnt_q, cool_cnt_d;
    logic             acked_q, acked_d;

    logic [IW-1:0]    rnd_idx_s;
    logic [IW-1:0]    sel_idx_s;
    logic             fire_s;
    logic [NCOIN-1:0] coin_req_s;
    logic             unused_s;

    // Coin lane that shares the track with a given obstacle spawner.
    function automatic int lane_of(input logic [IW-1:0] i);
        return int'(i) % NCOIN;
    endfunction

    assign unused_s = ^rnd;

    // Spawner selection with repeat avoidance, fire decision and per-lane coin requests.
    always_comb begin
        rnd_idx_s = rnd[IW-1:0];
        if (rnd_idx_s == last_idx_q) begin
            sel_idx_s = last_idx_q + IW'(1);
        end else begin
            sel_idx_s = rnd_idx_s;
        end
        fire_s = (state_q == S_READY) && frame_tick && (rnd[7:4] < THRESH_L)
                 && (obst_active == {NOBST{1'b0}});
        coin_req_s = {NCOIN{1'b0}};
        for (int i = 0; i < NCOIN; i++) begin
            coin_req_s[i] = (rnd[8+3*i +: 3] == 3'b111) && !coin_active[i]
                            && !(fire_s && (lane_of(sel_idx_s) == i));
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        obst_spawn_d  = obst_spawn_q;
        coin_spawn_d  = {NCOIN{1'b0}};
        spawn_count_d = spawn_count_q;
        miss_count_d  = miss_count_q;
        last_idx_d    = last_idx_q;
        idx_d         = idx_q;
        ack_cnt_d     = ack_cnt_q;
        cool_cnt_d    = cool_cnt_q;
        acked_d       = acked_q;

        if (!play) begin
            state_d      = S_IDLE;
            obst_spawn_d = {NOBST{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d      = S_READY;
                    obst_spawn_d = {NOBST{1'b0}};
                end
                S_READY: begin
                    if (fire_s) begin
                        obst_spawn_d = {{(NOBST-1){1'b0}}, 1'b1} << sel_idx_s;
                        idx_d        = sel_idx_s;
                        ack_cnt_d    = 4'd0;
                        acked_d      = 1'b0;
                        state_d      = S_FLIGHT;
                    end else begin
                        obst_spawn_d = {NOBST{1'b0}};
                    end
                end
                S_FLIGHT: begin
                    if (!acked_q) begin
                        // Ack wins over a timeout landing on the same cycle.
                        if (obst_active[idx_q]) begin
                            obst_spawn_d  = {NOBST{1'b0}};
                            last_idx_d    = idx_q;
                            acked_d       = 1'b1;
                            spawn_count_d = (spawn_count_q == 16'hFFFF) ? spawn_count_q
                                                                        : spawn_count_q + 16'd1;
                        end else if (frame_tick) begin
                            if (ack_cnt_q + 4'd1 >= ACK_TO_L) begin
                                obst_spawn_d = {NOBST{1'b0}};
                                miss_count_d = (miss_count_q == 8'hFF) ? miss_count_q
                                                                       : miss_count_q + 8'd1;
                                ack_cnt_d    = 4'd0;
                                cool_cnt_d   = COOL_L;
                                state_d      = S_COOL;
                            end else begin
                                ack_cnt_d = ack_cnt_q + 4'd1;
                            end
                        end else begin
                            ack_cnt_d = ack_cnt_q;
                        end
                    end else begin
                        if (obst_active == {NOBST{1'b0}}) begin
                            cool_cnt_d = COOL_L;
                            state_d    = S_COOL;
                        end else begin
                            state_d = S_FLIGHT;
                        end
                    end
                end
                S_COOL: begin
                    if (frame_tick) begin
                        if (cool_cnt_q <= 8'd1) begin
                            cool_cnt_d = 8'd0;
                            state_d    = S_READY;
                        end else begin
                            cool_cnt_d = cool_cnt_q - 8'd1;
                        end
                    end else begin
                        cool_cnt_d = cool_cnt_q;
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    obst_spawn_d = {NOBST{1'b0}};
                end
            endcase

            if ((state_q != S_IDLE) && frame_tick) begin
                coin_spawn_d = coin_req_s;
            end else begin
                coin_spawn_d = {NCOIN{1'b0}};
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            obst_spawn_q  <= {NOBST{1'b0}};
            coin_spawn_q  <= {NCOIN{1'b0}};
            spawn_count_q <= 16'd0;
            miss_count_q  <= 8'd0;
            last_idx_q    <= {IW{1'b0}};
            idx_q         <= {IW{1'b0}};
            ack_cnt_q     <= 4'd0;
            cool_cnt_q    <= 8'd0;
            acked_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            obst_spawn_q  <= obst_spawn_d;
            coin_spawn_q  <= coin_spawn_d;
            spawn_count_q <= spawn_count_d;
            miss_count_q  <= miss_count_d;
            last_idx_q    <= last_idx_d;
            idx_q         <= idx_d;
            ack_cnt_q     <= ack_cnt_d;
            cool_cnt_q    <= cool_cnt_d;
            acked_q       <= acked_d;
        end
    end

    assign obst_spawn  = obst_spawn_q;
    assign coin_spawn  = coin_spawn_q;
    assign state       = state_q;
    assign spawn_count = spawn_count_q;
    assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_spawn_scheduler.sv
// Scoreboard bench for spawn_scheduler: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares them, plus a coin-pulse monitor.
module tb_spawn_scheduler;

    logic        clk = 1'b0;
    logic        rst, play, frame_tick;
    logic [19:0] rnd;
    logic [3:0]  obst_active;
    logic [2:0]  coin_active;
    logic [3:0]  obst_spawn;
    logic [2:0]  coin_spawn;
    logic [1:0]  state;
    logic [15:0] spawn_count;
    logic [7:0]  miss_count;

    always #5 clk = ~clk;

    spawn_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .play        (play),
        .rnd         (rnd),
        .obst_active (obst_active),
        .coin_active (coin_active),
        .obst_spawn  (obst_spawn),
        .coin_spawn  (coin_spawn),
        .state       (state),
        .spawn_count (spawn_count),
        .miss_count  (miss_count)
    );

    typedef struct {
        int          due;
        logic [3:0]  obst;
        logic [2:0]  coin;
        logic [1:0]  st;
        logic [15:0] sc;
        logic [7:0]  mc;
    } exp_t;

    exp_t       exp_q[$];
    string      name_q[$];
    logic [2:0] coin_q[$];
    int         edges = 0;
    int         total = 0;
    int         bad   = 0;
    bit         done  = 1'b0;

    localparam logic [19:0] R_QUIET = 20'h000F0;
    localparam logic [19:0] R_FIRE2 = 20'h00022;
    localparam logic [19:0] R_THR   = 20'h00040;
    localparam logic [19:0] R_LOW   = 20'h00000;
    localparam logic [19:0] R_COIN  = 20'h1FFF0;
    localparam logic [19:0] R_BLK   = 20'h1FF01;

    always @(posedge clk) edges <= edges + 1;

    task automatic expect_next(input string nm, input logic [3:0] ob, input logic [2:0] cn,
                               input logic [1:0] st, input logic [15:0] sc, input logic [7:0] mc);
        exp_t e;
        e.due  = edges + 1;
        e.obst = ob;
        e.coin = cn;
        e.st   = st;
        e.sc   = sc;
        e.mc   = mc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input logic r, input logic p, input logic t, input logic [19:0] rn,
                        input logic [3:0] oa, input logic [2:0] ca);
        rst         = r;
        play        = p;
        frame_tick  = t;
        rnd         = rn;
        obst_active = oa;
        coin_active = ca;
        @(negedge clk);
    endtask

    // Monitor: compare every expectation that falls due, and every coin pulse seen.
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        logic [2:0] ec;
        while (exp_q.size() > 0 && exp_q[0].due == edges) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            total++;
            if ({obst_spawn, coin_spawn, state, spawn_count, miss_count} !==
                {e.obst, e.coin, e.st, e.sc, e.mc}) begin
                bad++;
                $display("FAIL %s: got obst=%b coin=%b st=%0d sc=%0d mc=%0d, want obst=%b coin=%b st=%0d sc=%0d mc=%0d",
                         nm, obst_spawn, coin_spawn, state, spawn_count, miss_count,
                         e.obst, e.coin, e.st, e.sc, e.mc);
            end
        end
        if (coin_spawn !== 3'b000) begin
            total++;
            if (coin_q.size() == 0) begin
                bad++;
                $display("FAIL coin_unexpected: got coin=%b, want no pulse", coin_spawn);
            end else begin
                ec = coin_q.pop_front();
                if (coin_spawn !== ec) begin
                    bad++;
                    $display("FAIL coin_pulse_mon: got coin=%b, want %b", coin_spawn, ec);
                end
            end
        end
        if (done) begin
            total++;
            if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL exp_leftover: got %0d pending, want 0", exp_q.size());
            end
            total++;
            if (coin_q.size() != 0) begin
                bad++;
                $display("FAIL coin_missing: got %0d unseen pulses, want 0", coin_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset overrides play and frame_tick.
        expect_next("reset", 4'b0000, 3'b000, 2'd0, 16'd0, 8'd0);
        step(1'b1, 1'b1, 1'b1, R_FIRE2, 4'b0000, 3'b000);
        expect_next("reset_hold", 4'b0000, 3'b000, 2'd0, 16'd0, 8'd0);
        step(1'b1, 1'b0, 1'b0, R_QUIET, 4'b0000, 3'b000);
        // Tick in IDLE is ignored; play moves to READY.
        expect_next("idle_to_ready", 4'b0000, 3'b000, 2'd1, 16'd0, 8'd0);
        step(1'b0, 1'b1, 1'b1, R_FIRE2, 4'b0000, 3'b000);
        expect_next("thresh_edge", 4'b0000, 3'b000, 2'd1, 16'd0, 8'd0);
        step(1'b0, 1'b1, 1'b1, R_THR, 4'b0000, 3'b000);
        expect_next("busy_block", 4'b0000, 3'b000, 2'd1, 16'd0, 8'd0);
        step(1'b0, 1'b1, 1'b1, R_LOW, 4'b0001, 3'b000);
        expect_next("fire_first", 4'b0100, 3'b000, 2'd2, 16'd0, 8'd0);
        step(1'b0, 1'b1, 1'b1, R_FIRE2, 4'b0000, 3'b000);
        expect_next("hold_req", 4'b0100, 3'b000, 2'd2, 16'd0, 8'd0);
        step(1'b0, 1'b1, 1'b0, R_QUIET, 4'b0000, 3'b000);
        expect_next("ack_clear", 4'b0000, 3'b000, 2'd2, 16'd1, 8'd0);
        step(1'b0, 1'b1, 1'b0, R_QUIET, 4'b0100, 3'b000);
        for (int i = 0; i < 2; i++) begin
            expect_next("busy_flight", 4'b0000, 3'b000, 2'd2, 16'd1, 8'd0);
            step(1'b0, 1'b1, 1'b1, R_QUIET, 4'b0100, 3'b000);
        end
        expect_next("enter_cool", 4'b0000, 3'b000, 2'd3, 16'd1, 8'd0);
        step(1'b0, 1'b1, 1'b0, R_QUIET, 4'b0000, 3'b000);
        for (int i = 0; i < 7; i++) begin
            expect_next("cool_count", 4'b0000, 3'b000, 2'd3, 16'd1, 8'd0);
            step(1'b0, 1'b1, 1'b1, R_QUIET, 4'b0000, 3'b000);
        end
        expect_next("cool_no_tick", 4'b0000, 3'b000, 2'd3, 16'd1, 8'd0);
        step(1'b0, 1'b1, 1'b0, R_QUIET, 4'b0000, 3'b000);
        expect_next("cool_done", 4'b0000, 3'b000, 2'd1, 16'd1, 8'd0);
        step(1'b0, 1'b1, 1'b1, R_QUIET, 4'b0000, 3'b000);
        // Same random index as last accepted spawner is bumped to the next one.
        expect_next("repeat_avoid", 4'b1000, 3'b000, 2'd2, 16'd1, 8'd0);
        step(1'b0, 1'b1, 1'b1, R_FIRE2, 4'b0000, 3'b000);
        for (int i = 0; i < 3; i++) begin
            expect_next("wait_ack", 4'b1000, 3'b000, 2'd2, 16'd1, 8'd0);
            step(1'b0, 1'b1, 1'b1, R_QUIET, 4'b0000, 3'b000);
        end
        expect_next("wait_no_tick", 4'b1000, 3'b000, 2'd2, 16'd1, 8'd0);
        step(1'b0, 1'b1, 1'b0, R_QUIET, 4'b0000, 3'b000);
        expect_next("timeout", 4'b0000, 3'b000, 2'd3, 16'd1, 8'd1);
        step(1'b0, 1'b1, 1'b1, R_QUIET, 4'b0000, 3'b000);
        // Coins: lane 1 busy, lanes 0 and 2 pulse once.
        expect_next("coin_pulse", 4'b0000, 3'b101, 2'd3, 16'd1, 8'd1);
        coin_q.push_back(3'b101);
        step(1'b0, 1'b1, 1'b1, R_COIN, 4'b0000, 3'b010);
        expect_next("coin_clear", 4'b0000, 3'b000, 2'd3, 16'd1, 8'd1);
        step(1'b0, 1'b1, 1'b0, R_QUIET, 4'b0000, 3'b000);
        // Dropping play mid-cooldown: coins suppressed, counts kept.
        expect_next("play_drop", 4'b0000, 3'b000, 2'd0, 16'd1, 8'd1);
        step(1'b0, 1'b0, 1'b1, R_COIN, 4'b0000, 3'b000);
        expect_next("idle_hold", 4'b0000, 3'b000, 2'd0, 16'd1, 8'd1);
        step(1'b0, 1'b0, 1'b0, R_QUIET, 4'b0000, 3'b000);
        expect_next("replay", 4'b0000, 3'b000, 2'd1, 16'd1, 8'd1);
        step(1'b0, 1'b1, 1'b0, R_QUIET, 4'b0000, 3'b000);
        // Fire to spawner 1 blocks coin lane 1 on the same tick.
        expect_next("lane_block", 4'b0010, 3'b101, 2'd2, 16'd1, 8'd1);
        coin_q.push_back(3'b101);
        step(1'b0, 1'b1, 1'b1, R_BLK, 4'b0000, 3'b000);
        // Reset mid-flight with an ack present: no count, request dropped.
        expect_next("rst_flight", 4'b0000, 3'b000, 2'd0, 16'd0, 8'd0);
        step(1'b1, 1'b1, 1'b1, R_QUIET, 4'b0010, 3'b000);
        expect_next("post_rst", 4'b0000, 3'b000, 2'd0, 16'd0, 8'd0);
        step(1'b0, 1'b0, 1'b0, R_QUIET, 4'b0000, 3'b000);
        done = 1'b1;
    end

endmodule
